cic_rate_controller: RTL and testbench
======================================

# cic_rate_controller

Sequencing controller for the CIC decimator in the receive DSP chain. Gates the input sample strobe into the CIC, owns the active decimation ratio, and performs glitch-free runtime ratio changes (complete period, flush, clear, settle) so downstream blocks never see outputs from a mixed-ratio integrator state. Sits between the ADC sample-strobe domain logic and the CIC, and is programmed from the control register bank.

## Interface
- STAGES, 3: CIC stage count. Default number of post-clear outputs suppressed.
- MAX_DECIMATION, 64: largest legal ratio.
- DEC_WIDTH, 7: width of ratio and phase fields. Must hold MAX_DECIMATION.
- DEFAULT_DECIMATION, 8: ratio loaded at reset.
- FLUSH_CYCLES, 4: idle cycles after the last period before clearing. Must be ≥1.
- SETTLE_OUTPUTS, STAGES: CIC outputs discarded after a clear.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  master run request.
- in_valid  in  1  upstream sample strobe.
- cfg_decimation  in  DEC_WIDTH  requested ratio.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted. Reset 1.
- cfg_err  out  1  one-cycle pulse on an illegal ratio. Reset 0.
- cic_valid  out  1  data_valid to the CIC. Reset 0.
- cic_clear_n  out  1  active-low synchronous clear to the CIC. Reset 0.
- cic_decimation  out  DEC_WIDTH  active ratio. Reset DEFAULT_DECIMATION.
- cic_out_valid  in  1  output_valid from the CIC.
- out_valid  out  1  gated output strobe to downstream. Reset 0.
- phase  out  DEC_WIDTH  input index within the current period. Reset 0.
- busy  out  1  high in DRAIN, FLUSH, CLEAR and SETTLE. Reset 0.
- dropped  out  1  one-cycle pulse when an in_valid is not forwarded while enable=1. Reset 0.
- drop_count  out  16  saturating count of dropped samples. Reset 0.

## Operation
- FSM states: IDLE, RUN, DRAIN, FLUSH, CLEAR, SETTLE. Reset state is IDLE.
- Config handshake: a transfer occurs when cfg_valid and cfg_ready are both high. cfg_ready=1 only in IDLE and RUN.
- A ratio is legal if 2 ≤ cfg_decimation ≤ MAX_DECIMATION. An illegal ratio still completes the handshake, pulses cfg_err next cycle, and is otherwise ignored.
- IDLE:
  - cic_valid=0 and phase=0. A legal config updates cic_decimation directly.
  - When enable=1, go to CLEAR.
- RUN:
  - cic_valid=in_valid.
  - phase increments on each in_valid and wraps from cic_decimation-1 to 0.
  - A legal config is latched as pending and the FSM goes to DRAIN.
- DRAIN:
  - cic_valid=in_valid until phase returns to 0, then go to FLUSH.
  - If phase is 0 on entry, go to FLUSH immediately. This includes an accept that coincides with the wrapping sample.
- FLUSH:
  - cic_valid=0. Every in_valid pulses dropped.
  - Hold for FLUSH_CYCLES cycles. cic_out_valid is still forwarded to out_valid.
  - Then go to CLEAR.
- CLEAR:
  - cic_clear_n=0 for exactly 2 cycles. cic_valid=0 and in_valid is dropped.
  - cic_decimation takes the pending ratio (if any) on the first cycle. phase=0.
  - Then go to SETTLE.
- SETTLE:
  - cic_valid=in_valid and phase counts as in RUN.
  - out_valid is suppressed for the first SETTLE_OUTPUTS cic_out_valid pulses.
  - Go to RUN on the cycle after the last suppressed pulse. If SETTLE_OUTPUTS=0, go directly to RUN.
- enable=0 in any state:
  - Go to IDLE next cycle. phase=0, any pending config is discarded, cic_clear_n returns to 1.
  - in_valid while enable=0 is not counted as dropped.
- Simultaneous enable=0 and a config accept in RUN: enable wins. The ratio is applied as in IDLE, with no DRAIN.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). cic_clear_n=0 during reset.

## Timing
- cic_valid = in_valid AND a registered state gate. It is combinational with zero latency, so the CIC samples data_in on the same edge.
- out_valid = cic_out_valid AND a registered not-suppress flag. Zero latency.
- cic_clear_n, cic_decimation, phase, busy, cfg_ready, cfg_err and dropped are registered.
- Reconfig latency, from accept to first forwarded sample: the remainder of the current period + FLUSH_CYCLES + 2 (CLEAR) + 1.
- Start from IDLE: the first forwarded sample is 3 cycles after enable rises.

## Configuration
- CIC_CTRL_DROP_CNT_EN defined: drop_count is a 16-bit saturating counter. It increments on each dropped pulse, holds at 0xFFFF, and clears only on reset.
- CIC_CTRL_DROP_CNT_EN undefined: drop_count is tied to 0 and no counter logic is generated. The dropped pulse is unaffected.

## Test plan
- Reset then enable=1 with continuous in_valid: cic_clear_n is low for 2 cycles, the first cic_valid comes 3 cycles after enable, cic_decimation=8, and phase cycles 0..7.
- In RUN at phase=3, cfg_decimation=16: 4 more samples are forwarded, then 4 FLUSH cycles with dropped pulses, then a 2-cycle clear, then cic_decimation=16. The first 3 cic_out_valid are masked, then out_valid follows cic_out_valid.
- Config 1, 0 and 65: cfg_err pulses each time, cic_decimation is unchanged, and the state stays RUN.
- Config accepted on the cycle of the phase-wrapping sample: DRAIN is skipped and FLUSH starts next cycle.
- enable dropped during SETTLE: IDLE next cycle, cic_valid=0, phase=0. Re-enable repeats the clear sequence.
- With CIC_CTRL_DROP_CNT_EN: one reconfig at full-rate in_valid gives drop_count=6. Without the macro, drop_count stays 0.

Source files
------------

// File: rtl/cic_rate_controller_if.sv
// Configuration bus between the control register bank and the CIC rate controller.
// The register bank drives the master side and the controller is the slave.
interface cic_rate_controller_if #(
    parameter int DEC_WIDTH = 7
);
    logic [DEC_WIDTH-1:0] cfg_decimation;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 cfg_err;

    modport master (
        output cfg_decimation,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_decimation,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/cic_rate_controller.sv
// Gates the sample strobe into the CIC and sequences glitch-free ratio changes (drain, flush, clear, settle).
// Define CIC_CTRL_DROP_CNT_EN to build the saturating drop_count counter; otherwise drop_count is tied to 0.
module cic_rate_controller #(
    parameter int STAGES             = 3,
    parameter int MAX_DECIMATION     = 64,
    parameter int DEC_WIDTH          = 7,
    parameter int DEFAULT_DECIMATION = 8,
    parameter int FLUSH_CYCLES       = 4,
    parameter int SETTLE_OUTPUTS     = STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    cic_rate_controller_if.slave cfg,
    output logic                 cic_valid,
    output logic                 cic_clear_n,
    output logic [DEC_WIDTH-1:0] cic_decimation,
    input  logic                 cic_out_valid,
    output logic                 out_valid,
    output logic [DEC_WIDTH-1:0] phase,
    output logic                 busy,
    output logic                 dropped,
    output logic [15:0]          drop_count
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_OUTPUTS + 2);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_OUTPUTS > 0) ? SETTLE_OUTPUTS - 1 : 0);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, CLEAR, SETTLE} state_t;

    state_t               state, state_nxt;
    logic [DEC_WIDTH-1:0] phase_nxt, phase_wrap, pending;
    logic                 pending_v;
    logic                 gate, pass;
    logic [FW-1:0]        flush_cnt;
    logic                 clr_second;
    logic [SW-1:0]        settle_cnt;
    logic                 accept, legal, sample, drop_now;

    assign accept   = cfg.cfg_valid && cfg.cfg_ready;
    assign legal    = (cfg.cfg_decimation >= DEC_WIDTH'(2)) &&
                      (cfg.cfg_decimation <= DEC_WIDTH'(MAX_DECIMATION));
    assign sample   = in_valid && gate;
    assign drop_now = enable && in_valid && !gate;

    // Zero-latency strobes: the CIC samples data on the same edge as in_valid.
    assign cic_valid = sample;
    assign out_valid = cic_out_valid && pass;

    assign phase_wrap = (phase == cic_decimation - DEC_WIDTH'(1)) ? '0 : phase + DEC_WIDTH'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt = state;
        phase_nxt = phase;
        if (!enable) begin
            state_nxt = IDLE;
            phase_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = CLEAR;
                    phase_nxt = '0;
                end
                RUN: begin
                    if (sample) phase_nxt = phase_wrap;
                    // An accept on the wrapping sample already sits on a period boundary.
                    if (accept && legal) state_nxt = (phase_nxt == '0) ? FLUSH : DRAIN;
                end
                DRAIN: begin
                    if (sample) begin
                        phase_nxt = phase_wrap;
                        if (phase_wrap == '0) state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) state_nxt = CLEAR;
                end
                CLEAR: begin
                    phase_nxt = '0;
                    if (clr_second) state_nxt = (SETTLE_OUTPUTS == 0) ? RUN : SETTLE;
                end
                SETTLE: begin
                    if (sample) phase_nxt = phase_wrap;
                    if (cic_out_valid && settle_cnt == SETTLE_LAST) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= '0;
            gate           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b0;
            cic_clear_n    <= 1'b0;
            cic_decimation <= DEC_WIDTH'(DEFAULT_DECIMATION);
            pending        <= '0;
            pending_v      <= 1'b0;
            flush_cnt      <= '0;
            clr_second     <= 1'b0;
            settle_cnt     <= '0;
            cfg.cfg_ready  <= 1'b1;
            cfg.cfg_err    <= 1'b0;
            dropped        <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            gate          <= state_nxt inside {RUN, DRAIN, SETTLE};
            pass          <= state_nxt inside {RUN, DRAIN, FLUSH};
            busy          <= state_nxt inside {DRAIN, FLUSH, CLEAR, SETTLE};
            cfg.cfg_ready <= state_nxt inside {IDLE, RUN};
            cic_clear_n   <= (state_nxt != CLEAR);
            cfg.cfg_err   <= accept && !legal;
            dropped       <= drop_now;
            flush_cnt     <= (state == FLUSH && state_nxt == FLUSH) ? flush_cnt + FW'(1) : '0;
            clr_second    <= (state == CLEAR && state_nxt == CLEAR);

            if (state_nxt != SETTLE)
                settle_cnt <= '0;
            else if (state == SETTLE && cic_out_valid)
                settle_cnt <= settle_cnt + SW'(1);

            // Outside an enabled RUN the ratio applies at once; in RUN it waits for the clear.
            if (accept && legal && (state == IDLE || !enable))
                cic_decimation <= cfg.cfg_decimation;
            else if (state == FLUSH && state_nxt == CLEAR && pending_v)
                cic_decimation <= pending;

            if (!enable || (state == FLUSH && state_nxt == CLEAR)) begin
                pending_v <= 1'b0;
            end else if (state == RUN && accept && legal) begin
                pending_v <= 1'b1;
                pending   <= cfg.cfg_decimation;
            end
        end
    end

`ifdef CIC_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt_q <= '0;
        else if (drop_now && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cic_rate_controller.sv
// Directed bench for cic_rate_controller: expected strobes are queued with their cycle stamps
// when stimulus is issued, and a negedge monitor pops and compares as the DUT presents them.
module tb_cic_rate_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic       cic_out_valid = 1'b0;
    logic       cic_valid, cic_clear_n, out_valid, busy, dropped;
    logic [6:0] cic_decimation, phase;
    logic [15:0] drop_count;

    cic_rate_controller_if #(.DEC_WIDTH(7)) cfg_if ();

    cic_rate_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .in_valid       (in_valid),
        .cfg            (cfg_if),
        .cic_valid      (cic_valid),
        .cic_clear_n    (cic_clear_n),
        .cic_decimation (cic_decimation),
        .cic_out_valid  (cic_out_valid),
        .out_valid      (out_valid),
        .phase          (phase),
        .busy           (busy),
        .dropped        (dropped),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ph;
        int dec;
    } fwd_t;

    fwd_t fwd_q[$];
    int   drop_q[$];
    int   out_q[$];
    int   err_q[$];

    int   cyc = 0;
    int   t0 = 0;
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dc_mark = 0;
    fwd_t e;
    int   ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic goto(input int c);
        while (cyc - t0 < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_fwd(input int c0, input int c1, input int base, input int dec);
        for (int c = c0; c <= c1; c++) fwd_q.push_back('{cyc: c, ph: (c - base) % dec, dec: dec});
    endtask

    task automatic push_drops(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) drop_q.push_back(c);
    endtask

    task automatic pulse_ov(input int c);
        goto(c);
        cic_out_valid = 1'b1;
        goto(c + 1);
        cic_out_valid = 1'b0;
    endtask

    task automatic cfg_req(input int c, input logic [6:0] val);
        goto(c);
        cfg_if.cfg_valid      = 1'b1;
        cfg_if.cfg_decimation = val;
        goto(c + 1);
        cfg_if.cfg_valid      = 1'b0;
    endtask

    // Monitor: every strobe the DUT raises must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && started) begin
            if (cic_valid) begin
                check("fwd_expected", fwd_q.size() != 0, 1);
                if (fwd_q.size() != 0) begin
                    e = fwd_q.pop_front();
                    check("fwd_cycle", cyc - t0, e.cyc);
                    check("fwd_phase", phase, e.ph);
                    check("fwd_ratio", cic_decimation, e.dec);
                end
            end
            if (dropped) begin
                check("drop_expected", drop_q.size() != 0, 1);
                if (drop_q.size() != 0) begin
                    ev = drop_q.pop_front();
                    check("drop_cycle", cyc - t0, ev);
                end
            end
            if (out_valid) begin
                check("out_expected", out_q.size() != 0, 1);
                if (out_q.size() != 0) begin
                    ev = out_q.pop_front();
                    check("out_cycle", cyc - t0, ev);
                end
            end
            if (cfg_if.cfg_err) begin
                check("err_expected", err_q.size() != 0, 1);
                if (err_q.size() != 0) begin
                    ev = err_q.pop_front();
                    check("err_cycle", cyc - t0, ev);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc - t0);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        cfg_if.cfg_valid      = 1'b0;
        cfg_if.cfg_decimation = 7'd8;
        in_valid              = 1'b1;
        cic_out_valid         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_if.cfg_ready, 1);
        check("rst_cfg_err", cfg_if.cfg_err, 0);
        check("rst_cic_valid", cic_valid, 0);
        check("rst_clear_n", cic_clear_n, 0);
        check("rst_ratio", cic_decimation, 8);
        check("rst_out_valid", out_valid, 0);
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped, 0);
        check("rst_drop_count", drop_count, 0);
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        cic_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Start from IDLE with continuous samples.
        t0       = cyc;
        started  = 1'b1;
        check("idle_clear_n", cic_clear_n, 1);
        enable   = 1'b1;
        in_valid = 1'b1;
        push_drops(1, 3);
        push_fwd(3, 13, 3, 8);
        goto(1);
        check("start_clear_n_c1", cic_clear_n, 0);
        check("start_busy", busy, 1);
        check("start_cfg_ready", cfg_if.cfg_ready, 0);
        goto(2);
        check("start_clear_n_c2", cic_clear_n, 0);
        goto(3);
        check("start_clear_n_c3", cic_clear_n, 1);
        check("start_ratio", cic_decimation, 8);
        pulse_ov(6);
        pulse_ov(9);
        pulse_ov(12);
        goto(13);
        check("run_busy", busy, 0);
        check("run_cfg_ready", cfg_if.cfg_ready, 1);

        // Reconfigure to 16 at phase 3.
        goto(14);
        out_q.push_back(14);
        cic_out_valid         = 1'b1;
        cfg_if.cfg_valid      = 1'b1;
        cfg_if.cfg_decimation = 7'd16;
        push_fwd(14, 18, 3, 8);
        push_drops(20, 25);
        push_fwd(25, 56, 25, 16);
        goto(15);
        cic_out_valid    = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        check("drain_cfg_ready", cfg_if.cfg_ready, 0);
        check("drain_busy", busy, 1);
        goto(19);
        check("flush_busy", busy, 1);
        dc_mark = int'(drop_count);
        goto(20);
        out_q.push_back(20);
        pulse_ov(20);
        goto(22);
        check("flush_ratio_old", cic_decimation, 8);
        goto(23);
        check("clear_ratio_new", cic_decimation, 16);
        check("clear_clear_n", cic_clear_n, 0);
        goto(25);
        check("settle_clear_n", cic_clear_n, 1);
        goto(26);
`ifdef CIC_CTRL_DROP_CNT_EN
        check("reconfig_drop_delta", int'(drop_count) - dc_mark, 6);
`else
        check("drop_count_tied", drop_count, 0);
`endif
        pulse_ov(27);
        pulse_ov(30);
        pulse_ov(33);
        goto(34);
        check("rerun_busy", busy, 0);
        goto(36);
        out_q.push_back(36);
        pulse_ov(36);

        // Illegal ratios complete the handshake but change nothing.
        err_q.push_back(42);
        err_q.push_back(44);
        err_q.push_back(46);
        cfg_req(41, 7'd1);
        cfg_req(43, 7'd0);
        cfg_req(45, 7'd65);
        goto(47);
        check("illegal_ratio_kept", cic_decimation, 16);
        check("illegal_busy", busy, 0);
        check("illegal_cfg_ready", cfg_if.cfg_ready, 1);

        // Accept coinciding with the wrapping sample skips DRAIN.
        goto(56);
        cfg_if.cfg_valid      = 1'b1;
        cfg_if.cfg_decimation = 7'd4;
        push_drops(58, 63);
        push_fwd(63, 67, 63, 4);
        goto(57);
        cfg_if.cfg_valid = 1'b0;
        check("wrap_busy", busy, 1);
        check("wrap_phase", phase, 0);
        check("wrap_cfg_ready", cfg_if.cfg_ready, 0);
        goto(61);
        check("wrap_clear_ratio", cic_decimation, 4);
        check("wrap_clear_n", cic_clear_n, 0);

        // Drop enable during SETTLE, program in IDLE, then re-enable.
        goto(67);
        enable = 1'b0;
        goto(68);
        check("idle_phase", phase, 0);
        check("idle_busy", busy, 0);
        check("idle_clear_n_back", cic_clear_n, 1);
        check("idle_cfg_ready", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid      = 1'b1;
        cfg_if.cfg_decimation = 7'd12;
        goto(69);
        cfg_if.cfg_valid = 1'b0;
        check("idle_ratio_direct", cic_decimation, 12);
        goto(70);
        enable = 1'b1;
        push_drops(71, 73);
        push_fwd(73, 79, 73, 12);
        goto(71);
        check("reenable_clear_n", cic_clear_n, 0);
        goto(80);
        in_valid = 1'b0;
        goto(90);

        check("fwd_left", fwd_q.size(), 0);
        check("drop_left", drop_q.size(), 0);
        check("out_left", out_q.size(), 0);
        check("err_left", err_q.size(), 0);
`ifdef CIC_CTRL_DROP_CNT_EN
        check("final_drop_count", drop_count, 18);
`else
        check("final_drop_count", drop_count, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
